// File: rtl/status_event_monitor.sv
// rtl/status_event_monitor.sv - status bus change detector with timestamped event FIFO
//
// Purpose:
//   Samples a status bus on every enabled cycle, turns every bit change into
//   a record {timestamp, change_mask, new_value} and queues it in a small
//   show-ahead FIFO drained over a valid/ready handshake. A record that finds
//   the FIFO full is dropped and a sticky overflow flag is raised instead of
//   stalling the status source.
//
// Ports:
//   sysclk     in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   enable     in   sample status_in and advance the timestamp
//   status_in  in   [WIDTH-1:0] monitored status bus
//   evt_valid  out  FIFO head holds a record
//   evt_ready  in   consumer accepts the head record
//   evt_data   out  [TS_W+2*WIDTH-1:0] head record {ts, mask, value}
//   evt_count  out  [clog2(DEPTH):0] number of records held
//   overflow   out  sticky record-dropped flag
//   clr_ovf    in   synchronous clear of overflow

module status_event_monitor #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          status_in,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [TS_W+2*WIDTH-1:0]   evt_data,
    output logic [$clog2(DEPTH):0]    evt_count,
    output logic                      overflow,
    input  logic                      clr_ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = TS_W + 2 * WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_prev;
    logic [TS_W-1:0]  r_ts;
    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic [WIDTH-1:0] w_mask;
    logic             w_push_req;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_mask     = status_in ^ r_prev;
    assign w_push_req = enable && (w_mask != '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = evt_valid && evt_ready;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Sampling and timestamp
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_prev <= '0;
            r_ts   <= '0;
        end else if (enable) begin
            r_prev <= status_in;
            r_ts   <= r_ts + TS_W'(1);
        end
    end

    // Record storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= {r_ts, w_mask, status_in};
        end
    end

    // Pointers and occupancy
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky overflow; a drop on the clearing edge wins.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_data  = r_mem[r_rptr];
    assign evt_count = r_count;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_status_event_monitor.sv
// tb/tb_status_event_monitor.sv - directed self-checking bench for status_event_monitor

module tb_status_event_monitor;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        enable;
    logic [8:0]  status_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [25:0] evt_data;
    logic [2:0]  evt_count;
    logic        overflow;
    logic        clr_ovf;

    int n_vec = 0;
    int n_err = 0;

    status_event_monitor #(.WIDTH(9), .DEPTH(4), .TS_W(8)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .enable    (enable),
        .status_in (status_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] rec(input logic [7:0] ts, input logic [8:0] m,
                                        input logic [8:0] v);
        return {ts, m, v};
    endfunction

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // Check the head record, then pop it with a single ready pulse.
    task automatic expect_pop(input string tag, input logic [25:0] exp);
        check_eq({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(evt_data), 32'(exp));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        status_in = 9'h000;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        #12;
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_count", 32'(evt_count), 32'd0);
        check_eq("rst_data",  32'(evt_data),  32'd0);
        check_eq("rst_ovf",   32'(overflow),  32'd0);
        reset = 1'b1;

        // Quiet bus: five enabled cycles, no records; ts must reach 5.
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("quiet_valid", 32'(evt_valid), 32'd0);
        end
        check_eq("quiet_count", 32'(evt_count), 32'd0);
        status_in = 9'h001;
        step();
        expect_pop("ts5", rec(8'h05, 9'h001, 9'h001));
        check_eq("ts5_empty", 32'(evt_valid), 32'd0);

        // First enabled edge after reset with non-zero status.
        do_reset();
        status_in = 9'h005;
        step();
        check_eq("first_count", 32'(evt_count), 32'd1);
        expect_pop("first", rec(8'h00, 9'h005, 9'h005));
        check_eq("first_empty", 32'(evt_valid), 32'd0);
        step();
        status_in = 9'h00C;
        step();
        expect_pop("chg", rec(8'h03, 9'h009, 9'h00C));
        step();
        step();
        check_eq("hold_valid", 32'(evt_valid), 32'd0);
        check_eq("hold_count", 32'(evt_count), 32'd0);

        // Overflow: six toggles with no consumer.
        do_reset();
        status_in = 9'h000;
        for (int i = 0; i < 6; i++) begin
            status_in = 9'(((i % 2) == 0) ? 1 : 0);
            step();
            if (i == 3) begin
                check_eq("ovf4_count", 32'(evt_count), 32'd4);
                check_eq("ovf4_flag",  32'(overflow),  32'd0);
            end
        end
        check_eq("ovf6_count", 32'(evt_count), 32'd4);
        check_eq("ovf6_flag",  32'(overflow),  32'd1);
        enable = 1'b0;
        expect_pop("drain0", rec(8'h00, 9'h001, 9'h001));
        expect_pop("drain1", rec(8'h01, 9'h001, 9'h000));
        expect_pop("drain2", rec(8'h02, 9'h001, 9'h001));
        expect_pop("drain3", rec(8'h03, 9'h001, 9'h000));
        check_eq("drain_empty", 32'(evt_valid), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop; prev=0, ts=6.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            status_in = 9'(((i % 2) == 0) ? 1 : 0);
            step();
        end
        check_eq("full_count", 32'(evt_count), 32'd4);
        status_in = 9'h001;
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check_eq("pp_count", 32'(evt_count), 32'd4);
        check_eq("pp_ovf",   32'(overflow),  32'd0);
        // Drop on the clearing edge: set wins.
        status_in = 9'h000;
        clr_ovf   = 1'b1;
        step();
        clr_ovf   = 1'b0;
        check_eq("setwin_ovf",   32'(overflow),  32'd1);
        check_eq("setwin_count", 32'(evt_count), 32'd4);
        enable = 1'b0;
        expect_pop("pp0", rec(8'h07, 9'h001, 9'h000));
        expect_pop("pp1", rec(8'h08, 9'h001, 9'h001));
        expect_pop("pp2", rec(8'h09, 9'h001, 9'h000));
        expect_pop("pp3", rec(8'h0A, 9'h001, 9'h001));
        check_eq("pp_empty", 32'(evt_valid), 32'd0);

        // Timestamp wrap, then asynchronous reset with records queued.
        do_reset();
        enable    = 1'b1;
        status_in = 9'h000;
        for (int i = 0; i < 255; i++) begin
            step();
        end
        check_eq("wrap_quiet", 32'(evt_count), 32'd0);
        status_in = 9'h001;
        step();
        status_in = 9'h000;
        step();
        status_in = 9'h001;
        step();
        check_eq("wrap_count", 32'(evt_count), 32'd3);
        check_eq("wrap_head", 32'(evt_data), 32'(rec(8'hFF, 9'h001, 9'h001)));
        enable    = 1'b0;
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check_eq("wrap_next", 32'(evt_data), 32'(rec(8'h00, 9'h001, 9'h000)));
        enable    = 1'b1;
        status_in = 9'h000;
        step();
        check_eq("pre_rst_count", 32'(evt_count), 32'd3);
        reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(evt_valid), 32'd0);
        check_eq("arst_count", 32'(evt_count), 32'd0);
        check_eq("arst_ovf",   32'(overflow),  32'd0);
        check_eq("arst_data",  32'(evt_data),  32'd0);
        #1;
        reset     = 1'b1;
        status_in = 9'h003;
        step();
        expect_pop("restart", rec(8'h00, 9'h003, 9'h003));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
